// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for the multicycle MIPS-subset datapath.
// Steps each instruction through fetch, decode, execute, memory and write-back and
// drives every datapath mux select and write enable from the current state.
//
// Optional feature macro: MULTICYCLE_MEM_WAIT_EN
//   defined   - FETCH, MEMRD and MEMWR stall while mem_ready=0; in FETCH, ir_write and
//               pc_write are asserted only in the cycle where mem_ready=1.
//   undefined - mem_ready is ignored; every memory state lasts one cycle.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset (forces FETCH, clears flags)
//   opcode[5:0]       Instr[31:26], sampled in DECODE and MEMADR
//   mem_ready         memory access complete (wait-state build only)
//   state[3:0]        current state encoding (debug)
//   pc_write .. pc_source   datapath controls
//   illegal_op        sticky unknown-opcode flag
//   instr_count[31:0] retired-instruction count (wraps)

module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic [3:0]  state,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExec     = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  // Control word layout:
  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
  //  reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]}
  function automatic logic [15:0] ctrl_of(state_e s);
    logic [15:0] c;
    c = '0;
    case (s)
      StFetch:              c = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
      StDecode:             c = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
      StMemAdr, StAddiExec: c = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
      StMemRd:              c = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
      StMemWb:              c = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
      StMemWr:              c = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
      StExec:               c = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
      StAluWb:              c = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
      StAddiWb:             c = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;
      StBranch:             c = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
      StJump:               c = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
      default:              c = '0;
    endcase
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] ctrl_q;
  logic [31:0] count_q;
  logic        illegal_q;
  logic        mem_ok;
  logic        retire;
  logic        bad_op;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  // mem_ready has no effect in this build.
  assign mem_ok = mem_ready | 1'b1;
`endif

  assign bad_op = !(opcode inside {OpR, OpLw, OpSw, OpBeq, OpAddi, OpJ});

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (mem_ok) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiExec;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:    if (mem_ok) state_d = StMemWb;
      StMemWr:    if (mem_ok) state_d = StFetch;
      StExec:     state_d = StAluWb;
      StAddiExec: state_d = StAddiWb;
      StMemWb, StAluWb, StAddiWb, StBranch, StJump: state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // Only the final state of a legal instruction counts; the illegal DECODE->FETCH exit does not.
  assign retire = (state_d == StFetch) &&
                  (state_q inside {StMemWb, StMemWr, StAluWb, StAddiWb, StBranch, StJump});

  // Controls are registered from the next state so they match the state register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      ctrl_q    <= ctrl_of(StFetch);
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
      if (retire) count_q <= count_q + 32'd1;
      if (state_q == StDecode && bad_op) illegal_q <= 1'b1;
    end
  end

  assign state         = state_q;
  assign pc_write_cond = ctrl_q[14];
  assign i_or_d        = ctrl_q[13];
  assign mem_read      = ctrl_q[12];
  assign mem_write     = ctrl_q[11];
  assign mem_to_reg    = ctrl_q[9];
  assign reg_dst       = ctrl_q[8];
  assign reg_write     = ctrl_q[7];
  assign alu_src_a     = ctrl_q[6];
  assign alu_src_b     = ctrl_q[5:4];
  assign alu_op        = ctrl_q[3:2];
  assign pc_source     = ctrl_q[1:0];
  assign illegal_op    = illegal_q;
  assign instr_count   = count_q;

`ifdef MULTICYCLE_MEM_WAIT_EN
  // In FETCH the PC and IR update only once the instruction word has arrived.
  assign pc_write = ctrl_q[15] & ((state_q != StFetch) | mem_ready);
  assign ir_write = ctrl_q[10] & mem_ready;
`else
  assign pc_write = ctrl_q[15];
  assign ir_write = ctrl_q[10];
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized scoreboard bench for multicycle_controller.
// The stimulus process expands each instruction into its expected per-cycle record
// (state, controls, flag, count) and queues them; a monitor pops one per cycle.

module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic [3:0]  state;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic        illegal_op;
  logic [31:0] instr_count;

  multicycle_controller dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .state        (state),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .illegal_op   (illegal_op),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    logic [15:0] ctrl;
    logic        illegal;
    logic [31:0] count;
  } rec_t;

  rec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;
  logic [31:0] model_count;
  logic        model_illegal;

  function automatic logic [15:0] dut_ctrl();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
            reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  // Expected controls from the per-state table, built field by field.
  function automatic logic [15:0] exp_ctrl(int st);
    logic pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa} = '0;
    asb = 0; aop = 0; psrc = 0;
    case (st)
      0:  begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2, 9: begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      10: rw = 1;
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      11: begin pw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Sequence of states an instruction walks through, from the opcode alone.
  function automatic int path_len(logic [5:0] op, output int p[6]);
    case (op)
      6'b100011: begin p = '{0, 1, 2, 3, 4, 0}; return 5; end
      6'b101011: begin p = '{0, 1, 2, 5, 0, 0}; return 4; end
      6'b000000: begin p = '{0, 1, 6, 7, 0, 0}; return 4; end
      6'b001000: begin p = '{0, 1, 9, 10, 0, 0}; return 4; end
      6'b000100: begin p = '{0, 1, 8, 0, 0, 0}; return 3; end
      6'b000010: begin p = '{0, 1, 11, 0, 0, 0}; return 3; end
      default:   begin p = '{0, 1, 0, 0, 0, 0}; return 2; end
    endcase
  endfunction

  // Called at the start of a FETCH cycle (posedge + 1).
  task automatic run_instr(input logic [5:0] op);
    int   p[6];
    int   n;
    rec_t r;
    n = path_len(op, p);
    opcode = op;
    for (int i = 0; i < n; i++) begin
      r.st = p[i]; r.ctrl = exp_ctrl(p[i]); r.illegal = model_illegal; r.count = model_count;
      exp_q.push_back(r);
    end
    repeat (n) @(posedge clk);
    #1;
    if (n == 2) model_illegal = 1'b1;
    else model_count = model_count + 32'd1;
  endtask

  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      rec_t r;
      r = exp_q.pop_front();
      chk($sformatf("state(exp %0d)", r.st), {28'd0, state}, r.st);
      chk($sformatf("ctrl(st %0d)", r.st), {16'd0, dut_ctrl()}, {16'd0, r.ctrl});
      chk("illegal_op", {31'd0, illegal_op}, {31'd0, r.illegal});
      chk("instr_count", instr_count, r.count);
    end
  end

`ifndef MULTICYCLE_MEM_WAIT_EN
  // mem_ready must be ignored in this build, so toggle it freely.
  always @(posedge clk) #2 mem_ready = 1'($urandom);
`endif

  logic [5:0] legal_ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100,
                               6'b000010};

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_count = 0;
    model_illegal = 0;
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    opcode = 6'b100011;
    mem_ready = 1'b1;
    model_count = 0;
    model_illegal = 0;
    #100;
    chk("reset state", {28'd0, state}, 32'd0);
    chk("reset count", instr_count, 32'd0);
    chk("reset illegal", {31'd0, illegal_op}, 32'd0);
    chk("reset ctrl", {16'd0, dut_ctrl()}, {16'd0, exp_ctrl(0)});
    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1;

    // Directed: LW then SW, R, ADDI, BEQ, J.
    run_instr(6'b100011);
    chk("count after lw", instr_count, 32'd1);
    foreach (legal_ops[i]) if (i > 0) run_instr(legal_ops[i]);
    chk("count after 6", instr_count, 32'd6);

    // Illegal opcode: sticky flag, count unchanged.
    run_instr(6'b111111);
    chk("illegal set", {31'd0, illegal_op}, 32'd1);
    chk("count after illegal", instr_count, 32'd6);
    run_instr(6'b000010);
    chk("illegal sticky", {31'd0, illegal_op}, 32'd1);

    // Reset during MEMRD clears asynchronously.
    mon_en = 0;
    opcode = 6'b100011;
    repeat (3) @(posedge clk);
    #1;
    chk("in memrd", {28'd0, state}, 32'd3);
    reset = 1'b1;
    #1;
    chk("async reset state", {28'd0, state}, 32'd0);
    chk("async reset count", instr_count, 32'd0);
    chk("async reset illegal", {31'd0, illegal_op}, 32'd0);
    do_reset();
    mon_en = 1;

`ifdef MULTICYCLE_MEM_WAIT_EN
    // Three wait cycles in FETCH, then the fetch completes.
    mon_en = 0;
    opcode = 6'b000010;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      @(negedge clk);
      chk("wait state", {28'd0, state}, 32'd0);
      chk("wait ir_write", {31'd0, ir_write}, {31'd0, mem_ready});
      chk("wait mem_read", {31'd0, mem_read}, 32'd1);
      @(posedge clk);
      #1;
    end
    chk("after wait", {28'd0, state}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    model_count = model_count + 32'd1;
    chk("wait count", instr_count, model_count);
    mon_en = 1;
`endif

    // Random instruction mix.
    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 5)];
      run_instr(op);
    end

    // Counter wrap.
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    model_count = 32'hFFFF_FFFF;
    run_instr(6'b000010);
    chk("count wrap", instr_count, 32'd0);

    @(negedge clk);
    chk("queue drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
